regfile_read_arbiter: RTL and testbench
=======================================

# regfile_read_arbiter

Round-robin arbiter that shares one 32-to-1, 32-bit register read multiplexer among several requesters (decode rs, decode rt, debug port). It owns the multiplexer's 5-bit select, grants one requester per cycle, and returns the selected word to the winner one cycle later. It sits between the register bank's read mux and the pipeline stages that read registers.

## Interface
- NREQ, 3, number of requesters (2..8)
- DW, 32, data width of the mux output
- AW, 5, select/address width (32 registers)

- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Req  in  NREQ  per-requester read request, level
- Addr  in  NREQ*AW  packed register addresses; requester i uses bits [i*AW +: AW]
- Stall  in  1  blocks new grants while high
- Gnt  out  NREQ  one-hot grant, registered
- Sel  out  AW  select driven to the shared 32:1 mux, registered
- RdData  in  DW  combinational output of the shared mux (Dout)
- RspValid  out  NREQ  one-hot response strobe, registered
- RspData  out  DW  returned register word, registered

## Operation
- Eligible set at each edge: Req[i] high AND Gnt[i] low AND Stall low. A requester holding Gnt is masked for that edge, so it cannot be granted on back-to-back edges.
- Round-robin pointer Ptr (index of the highest-priority requester). The winner is the first eligible requester at or after Ptr, wrapping modulo NREQ.
- On a grant to requester w:
  - Gnt <= onehot(w)
  - Sel <= Addr[w]
  - PendId <= w, Pend <= 1
  - Ptr <= (w+1) mod NREQ
- With no eligible requester: Gnt <= 0, Pend <= 0, Sel and Ptr hold.
- Response stage: if Pend, then RspValid <= onehot(PendId) and RspData <= RdData (see Configuration). Otherwise RspValid <= 0 and RspData holds.
- Requester protocol:
  - Hold Req and Addr stable until Gnt is seen high.
  - Addr is sampled only at the granting edge.
  - Req may stay high to request again; re-grant happens no earlier than two edges after the previous grant.
- Stall:
  - New grants are suppressed while Stall is high.
  - An already granted read still produces its response on the next edge.
  - Sel holds.
- Reset (any cycle, including with Pend set):
  - Gnt=0, Sel=0, RspValid=0, RspData=0, Pend=0, Ptr=0.
  - An in-flight response is discarded.
- Addr values outside 0..31 cannot occur (width is exactly AW).

## Timing
- Req high sampled at edge E:
  - Gnt and Sel valid from E to E+1.
  - The mux settles within that cycle.
  - RspValid and RspData valid from E+1 to E+2.
- Request-to-response latency is 2 edges.
- Throughput is one grant per cycle across requesters; per-requester maximum is one grant every 2 cycles.
- Gnt and RspValid are single-cycle pulses.
- All outputs change only on the rising edge of Clk; there is no combinational path from Req or Addr to any output.

## Configuration
- ARB_ZERO_REG_EN defined:
  - A granted read whose sampled Sel equals 0 returns RspData=0 regardless of RdData (MIPS $zero).
  - Grant, strobe and timing are unchanged.
- Undefined: RspData always equals RdData captured at the response edge.

## Test plan
All tests drive the mux stub as RdData = 0x100+Sel, with NREQ=3.
- Reset: assert Rst 2 cycles with Req=3'b111 -> Gnt=0, Sel=0, RspValid=0, RspData=0. First grant after release goes to requester 0.
- Single read: Req=3'b010, Addr1=5 at edge E -> Gnt=3'b010 and Sel=5 after E; RspValid=3'b010 and RspData=0x105 after E+1.
- Contention: Req=3'b111 held, Addr0/1/2=1/2/31 -> grants 0,1,2,0,... on consecutive edges. RspData sequence is 0x101, 0x102, 0x11F, each with the matching RspValid.
- Stall: Stall high the cycle after a grant to requester 2 -> its response still arrives. No Gnt while Stall is high; Sel holds. Rotation resumes at requester 0.
- Reset mid-operation: Rst high at the edge after a grant -> RspValid stays 0 and no response is delivered.
- Zero register: Addr0=0 -> with ARB_ZERO_REG_EN, RspData=0; without it, RspData=0x100.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Round-robin arbiter owning the select of a shared 32:1 register read mux.
// One requester is granted per cycle; the mux word is returned to the winner
// on the following edge.  A requester that holds a grant is masked for one
// edge, so no requester can win on back-to-back edges.
// Optional feature macro: ARB_ZERO_REG_EN -- when defined, a read of
// register 0 returns zero regardless of the mux output (MIPS $zero).
module regfile_read_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ*AW-1:0]  addr_i,
  input  logic                stall_i,
  input  logic [DW-1:0]       rd_data_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [AW-1:0]       sel_o,
  output logic [NREQ-1:0]     rsp_valid_o,
  output logic [DW-1:0]       rsp_data_o
);

  // Pointer/index width; the extra bit in IW absorbs ptr+k before wrapping.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = PW + 1;

  // Grant stage state
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]   sel_q, sel_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   pend_id_q, pend_id_d;

  // Response stage state
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  // Arbitration helpers
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [IW-1:0]   idx;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] pend_onehot;
  logic [AW-1:0]   addr_arr [NREQ];

  // Unpack the address bus and build one-hot decodes of the winner and the
  // pending requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]    = addr_i[gi*AW +: AW];
      assign win_onehot[gi]  = (win == PW'(gi));
      assign pend_onehot[gi] = (pend_id_q == PW'(gi));
    end
  endgenerate

  // Pick the first eligible requester at or after the pointer, wrapping.
  always_comb begin
    elig  = req_i & ~gnt_q & {NREQ{~stall_i}};
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + IW'(k);
      if (idx >= IW'(NREQ)) begin
        idx = idx - IW'(NREQ);
      end
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  // Next-state for the grant stage: grant the winner or idle with Sel/Ptr held.
  always_comb begin
    gnt_d     = '0;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    pend_d    = 1'b0;
    pend_id_d = pend_id_q;
    if (found) begin
      gnt_d     = win_onehot;
      sel_d     = addr_arr[win];
      pend_d    = 1'b1;
      pend_id_d = win;
      ptr_d     = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  // Next-state for the response stage.  sel_q still carries the address of
  // the pending read here, so it identifies the register being returned.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pend_q) begin
      rsp_valid_d = pend_onehot;
`ifdef ARB_ZERO_REG_EN
      rsp_data_d  = (sel_q == '0) ? '0 : rd_data_i;
`else
      rsp_data_d  = rd_data_i;
`endif
    end
  end

  // Grant stage registers; reset also cancels any pending read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
    end
  end

  // Response stage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed testbench for regfile_read_arbiter (NREQ=3).  The shared mux is
// modelled as RdData = 0x100 + Sel.
module tb_regfile_read_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;
  logic              stall;
  logic [DW-1:0]     rd_data;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     sel;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data = 32'h100 + 32'(sel);

  regfile_read_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .addr_i      (addr),
    .stall_i     (stall),
    .rd_data_i   (rd_data),
    .gnt_o       (gnt),
    .sel_o       (sel),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data)
  );

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b req=%b stall=%b gnt=%b sel=%0d rsp_valid=%b rsp_data=%h",
             $time, rst, req, stall, gnt, sel, rsp_valid, rsp_data);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; stall = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    addr = {5'd31, 5'd2, 5'd1};
    req = 3'b111; stall = 1'b0; rst = 1'b1;
    step(); step();
    n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    n_cmp++; if (sel !== 5'd0) begin n_err++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL reset_rv got=%b exp=000", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rd got=%h exp=0", rsp_data); end
    rst = 1'b0;
    step();
    n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL reset_first_gnt got=%b exp=001", gnt); end
    n_cmp++; if (sel !== 5'd1) begin n_err++; $display("FAIL reset_first_sel got=%0d exp=1", sel); end
  endtask

  task automatic test_single_read();
    do_reset();
    addr = {5'd0, 5'd5, 5'd0};
    req = 3'b010;
    step();
    n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt got=%b exp=010", gnt); end
    n_cmp++; if (sel !== 5'd5) begin n_err++; $display("FAIL single_sel got=%0d exp=5", sel); end
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL single_rv_early got=%b exp=000", rsp_valid); end
    req = 3'b000;
    step();
    n_cmp++; if (rsp_valid !== 3'b010) begin n_err++; $display("FAIL single_rv got=%b exp=010", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h105) begin n_err++; $display("FAIL single_rd got=%h exp=105", rsp_data); end
    n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL single_gnt_pulse got=%b exp=000", gnt); end
    step();
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL single_rv_pulse got=%b exp=000", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h105) begin n_err++; $display("FAIL single_rd_hold got=%h exp=105", rsp_data); end
  endtask

  task automatic test_contention();
    logic [2:0]  exp_gnt [5];
    logic [4:0]  exp_sel [5];
    logic [2:0]  exp_rv  [5];
    logic [31:0] exp_rd  [5];
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    exp_sel = '{5'd1, 5'd2, 5'd31, 5'd1, 5'd2};
    exp_rv  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_rd  = '{32'h0, 32'h101, 32'h102, 32'h11F, 32'h101};
    do_reset();
    addr = {5'd31, 5'd2, 5'd1};
    req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (gnt !== exp_gnt[i]) begin n_err++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt[i]); end
      n_cmp++; if (sel !== exp_sel[i]) begin n_err++; $display("FAIL cont_sel[%0d] got=%0d exp=%0d", i, sel, exp_sel[i]); end
      n_cmp++; if (rsp_valid !== exp_rv[i]) begin n_err++; $display("FAIL cont_rv[%0d] got=%b exp=%b", i, rsp_valid, exp_rv[i]); end
      n_cmp++; if (rsp_data !== exp_rd[i]) begin n_err++; $display("FAIL cont_rd[%0d] got=%h exp=%h", i, rsp_data, exp_rd[i]); end
    end
    req = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_gnt [4];
    exp_gnt = '{3'b001, 3'b000, 3'b001, 3'b000};
    do_reset();
    addr = {5'd0, 5'd0, 5'd7};
    req = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (gnt !== exp_gnt[i]) begin n_err++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt[i]); end
    end
    n_cmp++; if (rsp_valid !== 3'b001 || rsp_data !== 32'h107) begin
      n_err++; $display("FAIL b2b_rsp got=%b/%h exp=001/107", rsp_valid, rsp_data);
    end
    req = 3'b000;
  endtask

  task automatic test_stall();
    do_reset();
    addr = {5'd31, 5'd2, 5'd1};
    req = 3'b111;
    step(); step(); step();
    n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL stall_pre_gnt got=%b exp=100", gnt); end
    stall = 1'b1;
    step();
    n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL stall_gnt0 got=%b exp=000", gnt); end
    n_cmp++; if (sel !== 5'd31) begin n_err++; $display("FAIL stall_sel0 got=%0d exp=31", sel); end
    n_cmp++; if (rsp_valid !== 3'b100) begin n_err++; $display("FAIL stall_rv got=%b exp=100", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h11F) begin n_err++; $display("FAIL stall_rd got=%h exp=11f", rsp_data); end
    step();
    n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL stall_gnt1 got=%b exp=000", gnt); end
    n_cmp++; if (sel !== 5'd31) begin n_err++; $display("FAIL stall_sel1 got=%0d exp=31", sel); end
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL stall_rv1 got=%b exp=000", rsp_valid); end
    stall = 1'b0;
    step();
    n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL stall_resume_gnt got=%b exp=001", gnt); end
    n_cmp++; if (sel !== 5'd1) begin n_err++; $display("FAIL stall_resume_sel got=%0d exp=1", sel); end
    req = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr = {5'd0, 5'd5, 5'd0};
    req = 3'b010;
    step();
    n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rstmid_gnt got=%b exp=010", gnt); end
    rst = 1'b1; req = 3'b000;
    step();
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL rstmid_rv got=%b exp=000", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rstmid_rd got=%h exp=0", rsp_data); end
    rst = 1'b0;
    step();
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL rstmid_rv_late got=%b exp=000", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rstmid_rd_late got=%h exp=0", rsp_data); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] exp_rd;
`ifdef ARB_ZERO_REG_EN
    exp_rd = 32'h0;
`else
    exp_rd = 32'h100;
`endif
    do_reset();
    // Load a nonzero response first so a zeroed result is distinguishable.
    addr = {5'd0, 5'd0, 5'd9};
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    n_cmp++; if (rsp_data !== 32'h109) begin n_err++; $display("FAIL zero_pre_rd got=%h exp=109", rsp_data); end
    addr = {5'd0, 5'd0, 5'd0};
    req = 3'b001;
    step();
    n_cmp++; if (gnt !== 3'b001 || sel !== 5'd0) begin
      n_err++; $display("FAIL zero_gnt got=%b/%0d exp=001/0", gnt, sel);
    end
    req = 3'b000;
    step();
    n_cmp++; if (rsp_valid !== 3'b001) begin n_err++; $display("FAIL zero_rv got=%b exp=001", rsp_valid); end
    n_cmp++; if (rsp_data !== exp_rd) begin n_err++; $display("FAIL zero_rd got=%h exp=%h", rsp_data, exp_rd); end
  endtask

  initial begin
    rst = 1'b1; req = '0; addr = '0; stall = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_zero_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
